// File: rtl/izh_pkg.sv
// Shared types and constants for the time-multiplexed Izhikevich scheduler.
// Q9.7 fixed point: 16-bit two's complement with 7 fractional bits.
package izh_pkg;

  typedef logic signed [15:0] fx16_t;

  localparam fx16_t IZH_A      = 16'sh0018;
  localparam fx16_t IZH_B      = 16'sh0008;
  localparam fx16_t IZH_C      = 16'sh001E;
  localparam fx16_t IZH_D      = 16'sh0004;
  localparam fx16_t IZH_THRESH = 16'sh0F00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UPDATE,
    S_EMIT,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/izh_update.sv
// Combinational single-neuron Izhikevich next-state: (v, u, I) -> (v', u', spike).
// Intermediate products are 32-bit signed; results wrap to W bits.
module izh_update
  import izh_pkg::*;
#(
  parameter int W = 16
) (
  input  logic signed [W-1:0] v,
  input  logic signed [W-1:0] u,
  input  logic signed [W-1:0] i_cur,
  output logic signed [W-1:0] v_next,
  output logic signed [W-1:0] u_next,
  output logic                spike
);

  localparam logic signed [31:0] A32 = 32'(IZH_A);
  localparam logic signed [31:0] B32 = 32'(IZH_B);

  function automatic logic signed [31:0] sext32(input logic signed [W-1:0] x);
    return {{(32-W){x[W-1]}}, x};
  endfunction

  function automatic logic signed [W-1:0] wrap_w(input logic signed [31:0] x);
    return x[W-1:0];
  endfunction

  logic signed [31:0] v32;
  logic signed [31:0] u32;
  logic signed [31:0] i32;
  logic signed [31:0] vsq;
  logic signed [31:0] v_sum;
  logic signed [31:0] du;
  logic signed [31:0] u_sum;

  always_comb begin
    v32   = sext32(v);
    u32   = sext32(u);
    i32   = sext32(i_cur);
    vsq   = 32'sd2 * v32 * v32;
    v_sum = v32 + (vsq >>> 7) + 32'sd5 * v32 - u32 + i32;
    du    = (A32 * (B32 * v32 - u32)) >>> 7;
    u_sum = u32 + du;
    spike = (v >= IZH_THRESH);
    if (spike) begin
      v_next = IZH_C;
      u_next = u + IZH_D;
    end else begin
      v_next = wrap_w(v_sum);
      u_next = wrap_w(u_sum);
    end
  end

endmodule

// File: rtl/izh_scheduler.sv
// Walks N_NEURONS neurons through one shared Izhikevich datapath per tick,
// writing state back and emitting a valid/ready spike event per firing neuron.
module izh_scheduler
  import izh_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int ID_W      = $clog2(N_NEURONS),
  parameter int W         = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            tick,
  input  logic            cur_wr_en,
  input  logic [ID_W-1:0] cur_wr_addr,
  input  logic [W-1:0]    cur_wr_data,
  input  logic [ID_W-1:0] probe_addr,
  output logic [W-1:0]    probe_v,
  output logic            busy,
  output logic            step_done,
  output logic            overrun,
  output logic            spike_valid,
  input  logic            spike_ready,
  output logic [ID_W-1:0] spike_id
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_NEURONS - 1);

  sched_state_t state, state_n;
  logic [ID_W-1:0] idx;
  logic            last;
  logic            adv_idx;
  logic            start;

  logic signed [W-1:0] v_mem   [N_NEURONS];
  logic signed [W-1:0] u_mem   [N_NEURONS];
  logic signed [W-1:0] cur_mem [N_NEURONS];

  logic signed [W-1:0] v_p1;
  logic signed [W-1:0] u_p1;
  logic signed [W-1:0] i_p1;
  logic signed [W-1:0] v_upd;
  logic signed [W-1:0] u_upd;
  logic                spk;

  assign last  = (idx == LAST_IDX);
  assign start = (state == S_IDLE) && tick;

  always_comb begin
    state_n = state;
    adv_idx = 1'b0;
    unique case (state)
      S_IDLE:   if (tick) state_n = S_LOAD;
      S_LOAD:   state_n = S_UPDATE;
      S_UPDATE: begin
        if (spk) begin
          state_n = S_EMIT;
        end else if (last) begin
          state_n = S_DONE;
        end else begin
          state_n = S_LOAD;
          adv_idx = 1'b1;
        end
      end
      S_EMIT: begin
        if (spike_ready) begin
          if (last) begin
            state_n = S_DONE;
          end else begin
            state_n = S_LOAD;
            adv_idx = 1'b1;
          end
        end
      end
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      step_done   <= 1'b0;
      overrun     <= 1'b0;
      spike_valid <= 1'b0;
      spike_id    <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        idx <= '0;
      end else if (adv_idx) begin
        idx <= idx + 1'b1;
      end
      if (start) begin
        busy <= 1'b1;
      end else if (state == S_DONE) begin
        busy <= 1'b0;
      end
      step_done <= (state == S_DONE);
      // Any tick outside IDLE (including the DONE cycle) is dropped and flagged.
      if (tick && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      if ((state == S_UPDATE) && spk) begin
        spike_valid <= 1'b1;
        spike_id    <= idx;
      end else if ((state == S_EMIT) && spike_ready) begin
        spike_valid <= 1'b0;
      end
    end
  end

  // State file: cleared on reset, probe read registered without write-back bypass
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        v_mem[n]   <= '0;
        u_mem[n]   <= '0;
        cur_mem[n] <= '0;
      end
      probe_v <= '0;
    end else begin
      probe_v <= v_mem[probe_addr];
      if (cur_wr_en) begin
        cur_mem[cur_wr_addr] <= cur_wr_data;
      end
      if (state == S_UPDATE) begin
        v_mem[idx] <= v_upd;
        u_mem[idx] <= u_upd;
      end
    end
  end

  // Stage p1: operand latch, with same-cycle current write forwarded
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      v_p1 <= v_mem[idx];
      u_p1 <= u_mem[idx];
      i_p1 <= (cur_wr_en && (cur_wr_addr == idx)) ? cur_wr_data : cur_mem[idx];
    end
  end

  izh_update #(
    .W(W)
  ) u_update (
    .v      (v_p1),
    .u      (u_p1),
    .i_cur  (i_p1),
    .v_next (v_upd),
    .u_next (u_upd),
    .spike  (spk)
  );

endmodule

// File: tb/tb_izh_scheduler.sv
// Directed bench for izh_scheduler (N_NEURONS=4) with hand-computed expectations.
module tb_izh_scheduler;

  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int W    = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            tick = 1'b0;
  logic            cur_wr_en = 1'b0;
  logic [ID_W-1:0] cur_wr_addr = '0;
  logic [W-1:0]    cur_wr_data = '0;
  logic [ID_W-1:0] probe_addr = '0;
  logic [W-1:0]    probe_v;
  logic            busy;
  logic            step_done;
  logic            overrun;
  logic            spike_valid;
  logic            spike_ready = 1'b1;
  logic [ID_W-1:0] spike_id;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  izh_scheduler #(
    .N_NEURONS(N),
    .ID_W(ID_W),
    .W(W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .cur_wr_en   (cur_wr_en),
    .cur_wr_addr (cur_wr_addr),
    .cur_wr_data (cur_wr_data),
    .probe_addr  (probe_addr),
    .probe_v     (probe_v),
    .busy        (busy),
    .step_done   (step_done),
    .overrun     (overrun),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .spike_id    (spike_id)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick = 1'b0;
    cur_wr_en = 1'b0;
    spike_ready = 1'b1;
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  task automatic write_cur(input logic [ID_W-1:0] a, input logic [W-1:0] d);
    cur_wr_en = 1'b1;
    cur_wr_addr = a;
    cur_wr_data = d;
    cycle();
    cur_wr_en = 1'b0;
  endtask

  task automatic read_v(input logic [ID_W-1:0] a, output logic [W-1:0] val);
    probe_addr = a;
    cycle();
    val = probe_v;
  endtask

  // Pulses tick in cycle 0; lat is the cycle in which step_done is seen.
  task automatic run_step(output int lat, output int spikes);
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    lat = 1;
    spikes = 0;
    while (!step_done && lat < 200) begin
      if (spike_valid) spikes++;
      cycle();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cycle();
    cycle();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    tests++; if (step_done !== 1'b0) begin fails++; $display("FAIL reset_step_done: got %b, expected 0", step_done); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
    tests++; if (spike_valid !== 1'b0) begin fails++; $display("FAIL reset_spike_valid: got %b, expected 0", spike_valid); end
    tests++; if (spike_id !== 2'd0) begin fails++; $display("FAIL reset_spike_id: got %0d, expected 0", spike_id); end
    tests++; if (probe_v !== 16'h0000) begin fails++; $display("FAIL reset_probe_v: got %h, expected 0000", probe_v); end
    reset_n = 1'b1;
  endtask

  task automatic test_zero_step();
    int lat, sp;
    logic [W-1:0] val;
    do_reset();
    run_step(lat, sp);
    tests++; if (lat !== 10) begin fails++; $display("FAIL zero_latency: got %0d, expected 10", lat); end
    tests++; if (sp !== 0) begin fails++; $display("FAIL zero_spikes: got %0d, expected 0", sp); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy_at_done: got %b, expected 0", busy); end
    cycle();
    tests++; if (step_done !== 1'b0) begin fails++; $display("FAIL zero_done_pulse: got %b, expected 0", step_done); end
    for (int n = 0; n < N; n++) begin
      read_v(n[ID_W-1:0], val);
      tests++; if (val !== 16'h0000) begin fails++; $display("FAIL zero_v%0d: got %h, expected 0000", n, val); end
    end
  endtask

  task automatic test_current();
    int lat, sp;
    logic [W-1:0] val;
    logic [W-1:0] exp_v [N];
    do_reset();
    write_cur(2'd2, 16'h0A00);
    run_step(lat, sp);
    tests++; if (sp !== 0) begin fails++; $display("FAIL cur_spikes: got %0d, expected 0", sp); end
    exp_v = '{16'h0000, 16'h0000, 16'h0A00, 16'h0000};
    for (int n = 0; n < N; n++) begin
      read_v(n[ID_W-1:0], val);
      tests++; if (val !== exp_v[n]) begin fails++; $display("FAIL cur_v%0d: got %h, expected %h", n, val, exp_v[n]); end
    end
  endtask

  task automatic test_spike_stall();
    int lat, sp, c;
    logic [W-1:0] val;
    do_reset();
    write_cur(2'd1, 16'h0F00);
    run_step(lat, sp);
    tests++; if (lat !== 10 || sp !== 0) begin fails++; $display("FAIL stall_preload: got lat %0d spikes %0d, expected 10/0", lat, sp); end
    spike_ready = 1'b0;
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    c = 1;
    while (!spike_valid && c < 100) begin cycle(); c++; end
    tests++; if (c !== 5) begin fails++; $display("FAIL stall_valid_cycle: got %0d, expected 5", c); end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (spike_valid !== 1'b1 || spike_id !== 2'd1) begin
        fails++; $display("FAIL stall_hold%0d: got valid %b id %0d, expected 1/1", i, spike_valid, spike_id);
      end
      if (i == 5) spike_ready = 1'b1;
      cycle();
      c++;
    end
    spike_ready = 1'b0;
    tests++; if (spike_valid !== 1'b0) begin fails++; $display("FAIL stall_drop: got %b, expected 0", spike_valid); end
    while (!step_done && c < 100) begin cycle(); c++; end
    tests++; if (c !== 16) begin fails++; $display("FAIL stall_latency: got %0d, expected 16", c); end
    spike_ready = 1'b1;
    read_v(2'd1, val);
    tests++; if (val !== 16'h001E) begin fails++; $display("FAIL stall_reset_v: got %h, expected 001e", val); end
    read_v(2'd2, val);
    tests++; if (val !== 16'h0000) begin fails++; $display("FAIL stall_other_v: got %h, expected 0000", val); end
    // v=30, u=4, I=0: 30 + 14 + 150 - 4 = 190
    write_cur(2'd1, 16'h0000);
    run_step(lat, sp);
    read_v(2'd1, val);
    tests++; if (val !== 16'h00BE) begin fails++; $display("FAIL stall_u_effect: got %h, expected 00be", val); end
  endtask

  task automatic test_back_to_back();
    int lat, sp, c, n_ev;
    logic [ID_W-1:0] ids [4];
    do_reset();
    write_cur(2'd0, 16'h0F00);
    write_cur(2'd3, 16'h0F00);
    run_step(lat, sp);
    spike_ready = 1'b1;
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    c = 1;
    n_ev = 0;
    while (!step_done && c < 100) begin
      if (spike_valid) begin
        if (n_ev < 4) ids[n_ev] = spike_id;
        n_ev++;
      end
      cycle();
      c++;
    end
    tests++; if (n_ev !== 2) begin fails++; $display("FAIL b2b_events: got %0d, expected 2", n_ev); end
    tests++; if (ids[0] !== 2'd0) begin fails++; $display("FAIL b2b_first_id: got %0d, expected 0", ids[0]); end
    tests++; if (ids[1] !== 2'd3) begin fails++; $display("FAIL b2b_second_id: got %0d, expected 3", ids[1]); end
    tests++; if (c !== 12) begin fails++; $display("FAIL b2b_latency: got %0d, expected 12", c); end
  endtask

  task automatic test_overrun();
    int n_done, done_at, lat, sp;
    do_reset();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
    cycle();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    n_done = 0;
    done_at = 0;
    for (int c = 4; c < 34; c++) begin
      if (step_done) begin n_done++; done_at = c; end
      cycle();
    end
    tests++; if (n_done !== 1) begin fails++; $display("FAIL ovr_done_count: got %0d, expected 1", n_done); end
    tests++; if (done_at !== 10) begin fails++; $display("FAIL ovr_done_cycle: got %0d, expected 10", done_at); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b, expected 1", overrun); end
    run_step(lat, sp);
    tests++; if (lat !== 10) begin fails++; $display("FAIL ovr_next_step: got %0d, expected 10", lat); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b, expected 1", overrun); end
  endtask

  task automatic test_cur_bypass();
    int lat, sp, c;
    logic [W-1:0] val;
    do_reset();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
    cycle();
    write_cur(2'd0, 16'h0200);
    cycle();
    write_cur(2'd2, 16'h0100);
    c = 6;
    while (!step_done && c < 100) begin cycle(); c++; end
    tests++; if (c !== 10) begin fails++; $display("FAIL byp_latency: got %0d, expected 10", c); end
    read_v(2'd0, val);
    tests++; if (val !== 16'h0000) begin fails++; $display("FAIL byp_late_write: got %h, expected 0000", val); end
    read_v(2'd2, val);
    tests++; if (val !== 16'h0100) begin fails++; $display("FAIL byp_load_write: got %h, expected 0100", val); end
    // v2 = 256 + 1024 + 1280 + 256
    run_step(lat, sp);
    read_v(2'd0, val);
    tests++; if (val !== 16'h0200) begin fails++; $display("FAIL byp_next_step_v0: got %h, expected 0200", val); end
    read_v(2'd2, val);
    tests++; if (val !== 16'h0B00) begin fails++; $display("FAIL byp_next_step_v2: got %h, expected 0b00", val); end
  endtask

  task automatic test_negative();
    int lat, sp;
    logic [W-1:0] val;
    do_reset();
    write_cur(2'd0, 16'hFF00);
    run_step(lat, sp);
    write_cur(2'd0, 16'h0000);
    read_v(2'd0, val);
    tests++; if (val !== 16'hFF00) begin fails++; $display("FAIL neg_step1: got %h, expected ff00", val); end
    run_step(lat, sp);
    read_v(2'd0, val);
    tests++; if (val !== 16'hFE00 || sp !== 0) begin fails++; $display("FAIL neg_step2: got %h spikes %0d, expected fe00/0", val, sp); end
    run_step(lat, sp);
    read_v(2'd0, val);
    tests++; if (val !== 16'h0580 || sp !== 0) begin fails++; $display("FAIL neg_step3: got %h spikes %0d, expected 0580/0", val, sp); end
  endtask

  task automatic test_reset_emit();
    int lat, sp, c, n_done, n_vld;
    logic [W-1:0] val;
    do_reset();
    write_cur(2'd1, 16'h0F00);
    run_step(lat, sp);
    spike_ready = 1'b0;
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    c = 1;
    while (!spike_valid && c < 100) begin cycle(); c++; end
    tests++; if (spike_valid !== 1'b1) begin fails++; $display("FAIL rst_emit_reached: got %b, expected 1", spike_valid); end
    reset_n = 1'b0;
    cycle();
    tests++; if (spike_valid !== 1'b0) begin fails++; $display("FAIL rst_emit_valid: got %b, expected 0", spike_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_emit_busy: got %b, expected 0", busy); end
    reset_n = 1'b1;
    n_done = 0;
    n_vld = 0;
    for (int i = 0; i < 20; i++) begin
      if (step_done) n_done++;
      if (spike_valid) n_vld++;
      cycle();
    end
    tests++; if (n_done !== 0) begin fails++; $display("FAIL rst_emit_no_done: got %0d, expected 0", n_done); end
    tests++; if (n_vld !== 0) begin fails++; $display("FAIL rst_emit_no_valid: got %0d, expected 0", n_vld); end
    for (int n = 0; n < N; n++) begin
      read_v(n[ID_W-1:0], val);
      tests++; if (val !== 16'h0000) begin fails++; $display("FAIL rst_emit_v%0d: got %h, expected 0000", n, val); end
    end
    spike_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_zero_step();
    test_current();
    test_spike_stall();
    test_back_to_back();
    test_overrun();
    test_cur_bypass();
    test_negative();
    test_reset_emit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
